program_loader: RTL and testbench

//  Boot-time loader sitting upstream of the core's instruction RAM. It takes bytes

---
 rtl/loader_pkg.sv | 22 ++
 rtl/program_loader_if.sv | 27 ++
 rtl/word_assembler.sv | 40 ++++
 rtl/program_loader.sv | 124 ++++++++++++
 tb/tb_program_loader.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        ACK,
        RUN,
        ERR
    } state_t;

    localparam logic [7:0] ACK_OK_CODE  = 8'hAA;
    localparam logic [7:0] ACK_ERR_CODE = 8'h55;

    // Frame layout: LEN word, N data words, one checksum byte.
    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_BYTES = 1;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, response byte out, instruction RAM write port and core status.
interface program_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        wr_en_instr;
    logic [31:0] addr_in_instr;
    logic [31:0] data_in_instr;
    logic        core_start;
    logic        load_error;

    // Loader side.
    modport master (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, wr_en_instr, addr_in_instr, data_in_instr,
               core_start, load_error
    );

    // Environment side (UART, instruction RAM, core).
    modport slave (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, wr_en_instr, addr_in_instr, data_in_instr,
               core_start, load_error
    );
endinterface

// File: rtl/word_assembler.sv
// Collects four bytes little-endian into a 32-bit word. word/word_valid are
// combinational so the consumer sees the complete word in the cycle the 4th byte
// arrives.
module word_assembler (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,      // restart at lane 0; a byte in the same cycle is lane 0
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane_q;
    logic [1:0]  lane;
    logic [31:0] word_q;

    // Effective lane for this cycle and the word with the incoming byte inserted.
    always_comb begin
        lane = clear ? 2'd0 : lane_q;
        word = word_q;
        word[{lane, 3'b000} +: 8] = byte_in;
    end

    assign word_valid = byte_valid && (lane == 2'd3);

    // Lane counter and partial-word register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_q <= 2'd0;
            word_q <= 32'd0;
        end else if (byte_valid) begin
            lane_q <= lane + 2'd1;
            word_q <= word;
        end else if (clear) begin
            lane_q <= 2'd0;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: LEN | N words | XOR checksum from the UART into instruction RAM,
// then acknowledges and releases the core.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ACK_OK         = ACK_OK_CODE,
    parameter logic [7:0]  ACK_ERR        = ACK_ERR_CODE
) (
    input logic              clk,
    input logic              rstn,
    program_loader_if.master bus
);

    localparam logic [31:0] MAX_N    = 32'(MAX_WORDS);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state, next_state;
    logic [31:0] n_words, idx, tmo_cnt;
    logic [7:0]  csum;
    logic        wr_en_q, core_start_q, load_error_q;
    logic [31:0] addr_q, data_q;

    logic        in_frame, timeout, len_bad, last_word;
    logic        asm_valid, word_valid;
    logic [31:0] word;

    assign in_frame  = (state == LEN) || (state == DATA) || (state == CSUM);
    // A byte in the expiring cycle restarts the count instead of erroring.
    assign timeout   = in_frame && !bus.rx_valid && (tmo_cnt == TMO_LAST);
    assign len_bad   = (word == 32'd0) || (word > MAX_N);
    assign last_word = (idx + 32'd1) == n_words;
    assign asm_valid = bus.rx_valid && ((state == IDLE) || (state == LEN) || (state == DATA));

    word_assembler u_asm (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (state == IDLE),
        .byte_valid (asm_valid),
        .byte_in    (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.rx_valid) next_state = LEN;
            LEN: begin
                if (word_valid)   next_state = len_bad ? ERR : DATA;
                else if (timeout) next_state = ERR;
            end
            DATA: begin
                if (word_valid && last_word) next_state = CSUM;
                else if (timeout)            next_state = ERR;
            end
            CSUM: begin
                if (bus.rx_valid) next_state = (bus.rx_data == csum) ? ACK : ERR;
                else if (timeout) next_state = ERR;
            end
            ACK:     if (bus.tx_ready) next_state = RUN;
            ERR:     if (bus.tx_ready) next_state = IDLE;
            RUN:     next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // Frame datapath: length, word index, checksum, RAM write port, status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_words      <= 32'd0;
            idx          <= 32'd0;
            csum         <= 8'd0;
            tmo_cnt      <= 32'd0;
            wr_en_q      <= 1'b0;
            addr_q       <= 32'd0;
            data_q       <= 32'd0;
            core_start_q <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            tmo_cnt <= (in_frame && !bus.rx_valid) ? tmo_cnt + 32'd1 : 32'd0;
            case (state)
                IDLE: if (bus.rx_valid) begin
                    load_error_q <= 1'b0;
                    csum         <= 8'd0;
                    idx          <= 32'd0;
                end
                LEN: if (word_valid) n_words <= word;
                DATA: begin
                    if (bus.rx_valid) csum <= csum ^ bus.rx_data;
                    if (word_valid) begin
                        wr_en_q <= 1'b1;
                        addr_q  <= BASE_ADDR + (idx << 2);
                        data_q  <= word;
                        idx     <= idx + 32'd1;
                    end
                end
                ACK: if (bus.tx_ready) core_start_q <= 1'b1;
                default: ;
            endcase
            if (next_state == ERR && state != ERR) load_error_q <= 1'b1;
        end
    end

    // Response byte is a pure function of state, so it is stable while waiting.
    assign bus.tx_valid      = (state == ACK) || (state == ERR);
    assign bus.tx_data       = (state == ACK) ? ACK_OK : (state == ERR) ? ACK_ERR : 8'h00;
    assign bus.wr_en_instr   = wr_en_q;
    assign bus.addr_in_instr = addr_q;
    assign bus.data_in_instr = data_q;
    assign bus.core_start    = core_start_q;
    assign bus.load_error    = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: BASE 0x1000, MAX_WORDS 4, TIMEOUT 16.
module tb_program_loader;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    program_loader_if bus_if ();

    program_loader #(
        .BASE_ADDR      (32'h0000_1000),
        .MAX_WORDS      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    // Record every RAM write.
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus_if.wr_en_instr === 1'b1) begin
            wr_addr_q.push_back(bus_if.addr_in_instr);
            wr_data_q.push_back(bus_if.data_in_instr);
        end
    end

    // Called at posedge+1; byte captured at the next posedge, then one idle cycle.
    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        @(posedge clk); #1;
        bus_if.rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Two-word frame (0x00000013, 0x00100093); correct checksum is 0x90.
    task automatic send_frame(input logic [7:0] csum_b, input int from, input int upto);
        logic [7:0] f [0:12];
        f = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        f[12] = csum_b;
        for (int i = from; i <= upto; i++) send_byte(f[i]);
    endtask

    task automatic handshake;
        bus_if.tx_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.tx_ready = 1'b0;
    endtask

    task automatic do_reset;
        rstn            = 1'b0;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset;
        logic [75:0] obs;
        rstn            = 1'b0;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        obs = {bus_if.tx_valid, bus_if.tx_data, bus_if.wr_en_instr, bus_if.addr_in_instr,
               bus_if.data_in_instr, bus_if.core_start, bus_if.load_error};
        checks++;
        if (obs !== 76'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", obs);
        end
        do_reset();
    endtask

    task automatic test_load;
        do_reset();
        send_frame(8'h90, 0, 12);
        checks++;
        if (wr_addr_q.size() !== 2) begin
            errors++; $display("FAIL load_wr_count: got %0d want 2", wr_addr_q.size());
        end else begin
            checks++;
            if ({wr_addr_q[0], wr_data_q[0]} !== {32'h0000_1000, 32'h0000_0013}) begin
                errors++; $display("FAIL load_wr0: got %h/%h want 1000/13", wr_addr_q[0], wr_data_q[0]);
            end
            checks++;
            if ({wr_addr_q[1], wr_data_q[1]} !== {32'h0000_1004, 32'h0010_0093}) begin
                errors++; $display("FAIL load_wr1: got %h/%h want 1004/00100093", wr_addr_q[1], wr_data_q[1]);
            end
        end
        checks++;
        if ({bus_if.tx_valid, bus_if.tx_data, bus_if.core_start} !== {1'b1, 8'hAA, 1'b0}) begin
            errors++; $display("FAIL load_ack: got v=%b d=%h cs=%b want v=1 d=aa cs=0",
                               bus_if.tx_valid, bus_if.tx_data, bus_if.core_start);
        end
        handshake();
        checks++;
        if ({bus_if.core_start, bus_if.tx_valid, bus_if.load_error} !== 3'b100) begin
            errors++; $display("FAIL load_start: got cs/v/err=%b want 100",
                               {bus_if.core_start, bus_if.tx_valid, bus_if.load_error});
        end
    endtask

    task automatic test_bad_csum;
        do_reset();
        send_frame(8'h91, 0, 12);
        checks++;
        if ({bus_if.tx_valid, bus_if.tx_data, bus_if.load_error, bus_if.core_start} !== {1'b1, 8'h55, 1'b1, 1'b0}) begin
            errors++; $display("FAIL csum_err: got v=%b d=%h err=%b cs=%b want 1 55 1 0",
                               bus_if.tx_valid, bus_if.tx_data, bus_if.load_error, bus_if.core_start);
        end
        handshake();
        checks++;
        if ({bus_if.tx_valid, bus_if.load_error} !== 2'b01) begin
            errors++; $display("FAIL csum_after_hs: got v/err=%b want 01", {bus_if.tx_valid, bus_if.load_error});
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        send_frame(8'h90, 0, 0);
        checks++;
        if (bus_if.load_error !== 1'b0) begin
            errors++; $display("FAIL csum_err_clear: got %b want 0", bus_if.load_error);
        end
        send_frame(8'h90, 1, 12);
        checks++;
        if ({wr_addr_q.size(), bus_if.tx_data} !== {32'd2, 8'hAA}) begin
            errors++; $display("FAIL csum_retry: got n=%0d d=%h want n=2 d=aa", wr_addr_q.size(), bus_if.tx_data);
        end
        handshake();
        checks++;
        if (bus_if.core_start !== 1'b1) begin
            errors++; $display("FAIL csum_retry_start: got %b want 1", bus_if.core_start);
        end
    endtask

    task automatic test_len_range;
        logic [7:0] lens [0:2];
        lens = '{8'h00, 8'h05, 8'h04};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send_byte(lens[k]);
            send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
            if (k < 2) begin
                checks++;
                if ({bus_if.tx_valid, bus_if.tx_data, bus_if.load_error} !== {1'b1, 8'h55, 1'b1}) begin
                    errors++; $display("FAIL len_bad_%0d: got v=%b d=%h err=%b want 1 55 1", lens[k],
                                       bus_if.tx_valid, bus_if.tx_data, bus_if.load_error);
                end
                handshake();
            end else begin
                checks++;
                if ({bus_if.tx_valid, bus_if.load_error} !== 2'b00) begin
                    errors++; $display("FAIL len_max_ok: got v/err=%b want 00", {bus_if.tx_valid, bus_if.load_error});
                end
            end
        end
        checks++;
        if (wr_addr_q.size() !== 0) begin
            errors++; $display("FAIL len_no_writes: got %0d want 0", wr_addr_q.size());
        end
    endtask

    task automatic test_timeout;
        logic [7:0] f [0:5];
        f = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
        // Silence after byte 6: error lands on the 16th silent cycle.
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(f[i]);
        repeat (14) begin @(posedge clk); #1; end
        checks++;
        if (bus_if.tx_valid !== 1'b0) begin
            errors++; $display("FAIL tmo_early: got v=%b want 0", bus_if.tx_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus_if.tx_valid, bus_if.tx_data, bus_if.load_error} !== {1'b1, 8'h55, 1'b1}) begin
            errors++; $display("FAIL tmo_err: got v=%b d=%h err=%b want 1 55 1",
                               bus_if.tx_valid, bus_if.tx_data, bus_if.load_error);
        end
        handshake();
        // Byte on the 16th silent cycle wins over the timeout.
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(f[i]);
        repeat (14) begin @(posedge clk); #1; end
        send_byte(8'h00);
        checks++;
        if (bus_if.tx_valid !== 1'b0) begin
            errors++; $display("FAIL tmo_edge_byte: got v=%b want 0", bus_if.tx_valid);
        end
        send_byte(8'h00);
        send_byte(8'h13);
        checks++;
        if ({wr_addr_q.size(), bus_if.tx_valid, bus_if.tx_data} !== {32'd1, 1'b1, 8'hAA}) begin
            errors++; $display("FAIL tmo_edge_load: got n=%0d v=%b d=%h want 1 1 aa",
                               wr_addr_q.size(), bus_if.tx_valid, bus_if.tx_data);
        end else begin
            checks++;
            if ({wr_addr_q[0], wr_data_q[0]} !== {32'h0000_1000, 32'h0000_0013}) begin
                errors++; $display("FAIL tmo_edge_wr: got %h/%h want 1000/13", wr_addr_q[0], wr_data_q[0]);
            end
        end
        handshake();
    endtask

    task automatic test_tx_hold;
        int bad;
        do_reset();
        send_frame(8'h90, 0, 12);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 2) send_byte(8'h02);
            else begin @(posedge clk); #1; end
            if ({bus_if.tx_valid, bus_if.tx_data, bus_if.core_start} !== {1'b1, 8'hAA, 1'b0}) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
        end
        checks++;
        if (wr_addr_q.size() !== 2) begin
            errors++; $display("FAIL hold_drop_rx: got %0d writes want 2", wr_addr_q.size());
        end
        handshake();
        checks++;
        if (bus_if.core_start !== 1'b1) begin
            errors++; $display("FAIL hold_start: got %b want 1", bus_if.core_start);
        end
        for (int i = 0; i < 4; i++) send_byte(8'h02);
        checks++;
        if ({wr_addr_q.size(), bus_if.tx_valid, bus_if.core_start} !== {32'd2, 1'b0, 1'b1}) begin
            errors++; $display("FAIL run_ignore: got n=%0d v=%b cs=%b want 2 0 1",
                               wr_addr_q.size(), bus_if.tx_valid, bus_if.core_start);
        end
    endtask

    task automatic test_async_reset;
        logic [75:0] obs;
        do_reset();
        send_frame(8'h90, 0, 9);
        checks++;
        if (wr_addr_q.size() !== 1) begin
            errors++; $display("FAIL arst_pre_writes: got %0d want 1", wr_addr_q.size());
        end
        #2 rstn = 1'b0;
        #1;
        obs = {bus_if.tx_valid, bus_if.tx_data, bus_if.wr_en_instr, bus_if.addr_in_instr,
               bus_if.data_in_instr, bus_if.core_start, bus_if.load_error};
        checks++;
        if (obs !== 76'd0) begin
            errors++; $display("FAIL arst_outputs: got %h want 0", obs);
        end
        @(posedge clk); #1 rstn = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        send_frame(8'h90, 0, 12);
        checks++;
        if ({wr_addr_q.size(), bus_if.tx_data} !== {32'd2, 8'hAA}) begin
            errors++; $display("FAIL arst_reload: got n=%0d d=%h want 2 aa", wr_addr_q.size(), bus_if.tx_data);
        end else begin
            checks++;
            if (wr_data_q[1] !== 32'h0010_0093) begin
                errors++; $display("FAIL arst_reload_wr1: got %h want 00100093", wr_data_q[1]);
            end
        end
        handshake();
        checks++;
        if (bus_if.core_start !== 1'b1) begin
            errors++; $display("FAIL arst_start: got %b want 1", bus_if.core_start);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_bad_csum();
        test_len_range();
        test_timeout();
        test_tx_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule
